// File: rtl/seq_match_pkg.sv
// Shared types for the run-controlled serial pattern detector.
package seq_match_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/seq_match_shift.sv
// Pattern shift register with fill counter; hit is the combinational match
// of the history plus the bit being sampled right now.
module seq_match_shift #(
    parameter int PAT_W = 3
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             w,
    input  logic [PAT_W-1:0] pattern,
    output logic             hit
);

    localparam int FILL_W = $clog2(PAT_W + 1);

    logic [PAT_W-2:0]  sr;
    logic [PAT_W-1:0]  sr_nxt;
    logic [FILL_W-1:0] fill;

    assign sr_nxt = {sr, w};
    // Only PAT_W-1 history bits are kept; the newest bit completes the window.
    assign hit    = shift_en && (fill >= FILL_W'(PAT_W - 1)) && (sr_nxt == pattern);

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            sr   <= '0;
            fill <= '0;
        end else if (clr) begin
            sr   <= '0;
            fill <= '0;
        end else if (shift_en) begin
            sr <= sr_nxt[PAT_W-2:0];
            if (fill != FILL_W'(PAT_W)) fill <= fill + 1'b1;
        end
    end

endmodule

// File: rtl/seq_match_ctrl.sv
// Run controller for the serial pattern detector: arms, counts bits and
// matches, and ends the run on window expiry or stop.
module seq_match_ctrl
    import seq_match_pkg::*;
#(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8,
    parameter int WIN_W = 8
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             start,
    input  logic             stop,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [WIN_W-1:0] cfg_len,
    input  logic             w,
    input  logic             w_valid,
    output logic             q,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat,
    output logic [1:0]       dbg_state
);

    // Stream handshake: w is taken on any RUN cycle with w_valid=1 and
    // stop=0; there is no ready, so the source is never back-pressured.

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [WIN_W-1:0] WIN_MAX = {WIN_W{1'b1}};

    state_t           state;
    logic [PAT_W-1:0] pattern_r;
    logic [WIN_W-1:0] len_r;
    logic [WIN_W-1:0] bitcnt;
    logic             sample;
    logic             clr;
    logic             last_bit;
    logic             hit;

    assign sample    = (state == S_RUN) && w_valid && !stop;
    assign clr       = (state == S_IDLE) && start;
    assign last_bit  = (len_r != '0) && ((bitcnt + 1'b1) == len_r);
    assign dbg_state = state;

    seq_match_shift #(.PAT_W(PAT_W)) u_shift (
        .clk      (clk),
        .arstn    (arstn),
        .clr      (clr),
        .shift_en (sample),
        .w        (w),
        .pattern  (pattern_r),
        .hit      (hit)
    );

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state     <= S_IDLE;
            pattern_r <= '0;
            len_r     <= '0;
            bitcnt    <= '0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
            q         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            q    <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pattern_r <= cfg_pattern;
                        len_r     <= cfg_len;
                        bitcnt    <= '0;
                        match_cnt <= '0;
                        cnt_sat   <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_ARM;
                    end
                end
                S_ARM: begin
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (w_valid) begin
                        if (bitcnt != WIN_MAX) bitcnt <= bitcnt + 1'b1;
                        if (hit) begin
                            q <= 1'b1;
                            if (match_cnt == CNT_MAX) cnt_sat   <= 1'b1;
                            else                      match_cnt <= match_cnt + 1'b1;
                        end
                        // The window-closing bit is still matched above.
                        if (last_bit) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
